// File: rtl/lane_skew_unit_if.sv
// Bundle of per-lane data/valid, pipeline controls and status for lane_skew_unit.
// The producer/monitor side uses the master modport; the delay unit uses slave.
interface lane_skew_unit_if #(
  parameter int LANES      = 16,
  parameter int DATA_WIDTH = 32
);
  logic                        shift_en;
  logic                        flush;
  logic [LANES-1:0]            lane_mask;
  logic                        err_clear;
  logic [LANES*DATA_WIDTH-1:0] data_in;
  logic [LANES-1:0]            valid_in;
  logic [LANES*DATA_WIDTH-1:0] data_out;
  logic [LANES-1:0]            valid_out;
  logic                        aligned_valid;
  logic                        align_err;
  logic                        drain_busy;

  modport master (
    output shift_en, flush, lane_mask, err_clear, data_in, valid_in,
    input  data_out, valid_out, aligned_valid, align_err, drain_busy
  );

  modport slave (
    input  shift_en, flush, lane_mask, err_clear, data_in, valid_in,
    output data_out, valid_out, aligned_valid, align_err, drain_busy
  );
endinterface

// File: rtl/lane_skew_unit.sv
// Per-lane delay line: lane i is delayed by i*STRIDE cycles (skew) or by
// (LANES-1-i)*STRIDE cycles (de-skew), with stall, flush, masking and status.
module lane_skew_unit #(
  parameter int LANES      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRIDE     = 1,
  parameter int DESKEW     = 0
) (
  input logic             clk,
  input logic             rst,
  lane_skew_unit_if.slave bus
);

  if (LANES < 2) begin : g_bad_lanes
    $error("lane_skew_unit: LANES must be at least 2");
  end
  if (STRIDE < 1) begin : g_bad_stride
    $error("lane_skew_unit: STRIDE must be at least 1");
  end

  // Pipelines advance only on a non-flush shift edge.
  logic shift_go;
  assign shift_go = bus.shift_en & ~bus.flush;

  logic [LANES-1:0]      lane_valid;
  logic [LANES-1:0]      lane_busy;
  logic [DATA_WIDTH-1:0] lane_data [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int DEPTH = (DESKEW != 0) ? (LANES - 1 - gi) * STRIDE : gi * STRIDE;

    if (DEPTH == 0) begin : g_comb
      assign lane_valid[gi] = bus.valid_in[gi] & shift_go;
      assign lane_data[gi]  = bus.data_in[gi*DATA_WIDTH +: DATA_WIDTH];
      assign lane_busy[gi]  = 1'b0;
    end else begin : g_pipe
      logic [DATA_WIDTH-1:0] data_reg [DEPTH];
      logic [DEPTH-1:0]      valid_reg;

      // Flush drops in-flight valids but leaves the data stages untouched.
      always_ff @(posedge clk) begin
        if (!rst) begin
          valid_reg <= '0;
          for (int n = 0; n < DEPTH; n++) begin
            data_reg[n] <= '0;
          end
        end else if (bus.flush) begin
          valid_reg <= '0;
        end else if (bus.shift_en) begin
          valid_reg[0] <= bus.valid_in[gi];
          data_reg[0]  <= bus.data_in[gi*DATA_WIDTH +: DATA_WIDTH];
          for (int n = 1; n < DEPTH; n++) begin
            valid_reg[n] <= valid_reg[n-1];
            data_reg[n]  <= data_reg[n-1];
          end
        end
      end

      assign lane_valid[gi] = valid_reg[DEPTH-1];
      assign lane_data[gi]  = data_reg[DEPTH-1];
      assign lane_busy[gi]  = |valid_reg;
    end

    assign bus.data_out[gi*DATA_WIDTH +: DATA_WIDTH] =
      (rst && bus.lane_mask[gi]) ? lane_data[gi] : '0;
  end

  logic [LANES-1:0] vis_valid;
  logic [LANES-1:0] en_valid;
  assign en_valid  = lane_valid & bus.lane_mask;
  assign vis_valid = en_valid & {LANES{rst}};

  assign bus.valid_out     = vis_valid;
  // Masked lanes count as valid, but an all-masked unit never reports alignment.
  assign bus.aligned_valid = rst & (|bus.lane_mask) & (&(vis_valid | ~bus.lane_mask));
  assign bus.drain_busy    = rst & (|lane_busy);

  logic err_set;
  logic align_err_reg;
  logic align_err_next;

  assign err_set = shift_go & (|en_valid) & (en_valid != bus.lane_mask);

  always_comb begin
    align_err_next = align_err_reg;
    if (err_set) begin
      align_err_next = 1'b1;
    end else if (bus.err_clear) begin
      align_err_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      align_err_reg <= 1'b0;
    end else begin
      align_err_reg <= align_err_next;
    end
  end

  // A skewing instance never reports misalignment; its lanes are staggered by design.
  assign bus.align_err = (DESKEW != 0) & rst & align_err_reg;

endmodule
